i2c_single_reg_master: RTL and testbench

I2C_SINGLE_REG_MASTER -- requirements
Module: i2c_single_reg_master

---
 rtl/i2c_single_reg_master.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_single_reg_master.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_single_reg_master.sv
// Single-transaction I2C master: START, address byte, ACK, one data byte, ACK, STOP.
// Each bit spans four quarters of PRESCALE clk cycles. SCL/SDA are open-drain style
// (0 pulls low, 1 releases) and registered so the pins never glitch.
// Optional feature: define I2C_MASTER_CLK_STRETCH_EN to let a slave stretch SCL.
module i2c_single_reg_master #(
    parameter int unsigned PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       scl_t,
    output logic       sda_o,
    output logic       sda_t,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       busy
);

    localparam logic [7:0] PresLast = 8'(PRESCALE - 1);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StStop
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] presc_q, presc_d;
    logic [1:0] quarter_q, quarter_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] addr_byte_q, addr_byte_d;
    logic [7:0] wdata_q, wdata_d;
    logic       read_q, read_d;
    logic [7:0] rx_q, rx_d;
    logic       nack_q, nack_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;

    logic stretch_hold;
    logic quarter_tick;
    logic bit_end;

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // Released SCL that still reads low means a slave is stretching: freeze the quarter.
    assign stretch_hold = (state_q != StIdle) && quarter_q[1] && scl_q && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stretch_hold = 1'b0;
`endif

    assign quarter_tick = (presc_q == PresLast) && !stretch_hold;
    assign bit_end      = quarter_tick && (quarter_q == 2'd3);

    // Next-state: command capture, quarter/bit timing, byte sequencing and response.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        addr_byte_d = addr_byte_q;
        wdata_d     = wdata_q;
        read_d      = read_q;
        rx_d        = rx_q;
        nack_d      = nack_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        scl_d       = 1'b1;
        sda_d       = 1'b1;

        if (state_q == StIdle) begin
            if (cmd_valid) begin
                state_d     = StStart;
                presc_d     = 8'd0;
                quarter_d   = 2'd0;
                bit_d       = 3'd7;
                addr_byte_d = {cmd_addr, cmd_read};
                wdata_d     = cmd_wdata;
                read_d      = cmd_read;
                nack_d      = 1'b0;
            end
        end else begin
            if (!stretch_hold) begin
                presc_d = quarter_tick ? 8'd0 : presc_q + 8'd1;
            end
            if (quarter_tick) begin
                quarter_d = quarter_q + 2'd1;
            end
            if (bit_end) begin
                unique case (state_q)
                    StStart: begin
                        state_d = StAddr;
                        bit_d   = 3'd7;
                    end
                    StAddr: begin
                        if (bit_q == 3'd0) state_d = StAddrAck;
                        else bit_d = bit_q - 3'd1;
                    end
                    StAddrAck: begin
                        bit_d = 3'd7;
                        if (sda_i) begin
                            nack_d  = 1'b1;
                            state_d = StStop;
                        end else begin
                            state_d = read_q ? StRead : StWrite;
                        end
                    end
                    StWrite: begin
                        if (bit_q == 3'd0) state_d = StWriteAck;
                        else bit_d = bit_q - 3'd1;
                    end
                    StWriteAck: begin
                        nack_d  = sda_i;
                        state_d = StStop;
                    end
                    StRead: begin
                        rx_d[bit_q] = sda_i;
                        if (bit_q == 3'd0) state_d = StReadAck;
                        else bit_d = bit_q - 3'd1;
                    end
                    StReadAck: begin
                        state_d = StStop;
                    end
                    StStop: begin
                        state_d     = StIdle;
                        rsp_valid_d = 1'b1;
                        rsp_nack_d  = nack_q;
                        if (read_q && !nack_q) rsp_data_d = rx_q;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        // Pin levels follow the upcoming state so SDA changes exactly at q0 entry.
        case (state_d)
            StStart: begin
                scl_d = 1'b1;
                sda_d = !quarter_d[1];
            end
            StAddr: begin
                scl_d = quarter_d[1];
                sda_d = addr_byte_q[bit_d];
            end
            StWrite: begin
                scl_d = quarter_d[1];
                sda_d = wdata_q[bit_d];
            end
            StAddrAck, StWriteAck, StRead, StReadAck: begin
                scl_d = quarter_d[1];
                sda_d = 1'b1;
            end
            StStop: begin
                scl_d = (quarter_d != 2'd0);
                sda_d = (quarter_d == 2'd3);
            end
            default: begin
                scl_d = 1'b1;
                sda_d = 1'b1;
            end
        endcase
    end

    // State register with synchronous active-low reset; a reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            presc_q     <= 8'd0;
            quarter_q   <= 2'd0;
            bit_q       <= 3'd0;
            addr_byte_q <= 8'd0;
            wdata_q     <= 8'd0;
            read_q      <= 1'b0;
            rx_q        <= 8'd0;
            nack_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_nack_q  <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            addr_byte_q <= addr_byte_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            rx_q        <= rx_d;
            nack_q      <= nack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
        end
    end

    assign scl_o     = scl_q;
    assign scl_t     = scl_q;
    assign sda_o     = sda_q;
    assign sda_t     = sda_q;
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_i2c_single_reg_master.sv
// Bench for i2c_single_reg_master: an edge-driven slave at 7'h70 plus a bus monitor,
// with expected bus frames and responses queued at stimulus time and checked on rsp_valid.
module tb_i2c_single_reg_master;

    localparam int unsigned PRESCALE = 8;
    localparam int unsigned TXN      = 20 * 4 * PRESCALE;
`ifdef I2C_MASTER_CLK_STRETCH_EN
    localparam int unsigned STRETCH_EXTRA = 40;
`else
    localparam int unsigned STRETCH_EXTRA = 0;
`endif
    localparam logic [6:0] SLAVE_ADDR = 7'h70;

    logic       clk;
    logic       rst;
    logic       scl_i, sda_i, scl_o, scl_t, sda_o, sda_t;
    logic       cmd_valid, cmd_ready, cmd_read;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_nack, busy;
    logic [7:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_count = 0;

    // Slave / monitor state
    logic       slv_sda = 1'b1;
    logic       hold_low = 1'b0;
    int         hold_cnt = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         fb = 0;
    int         bi = 0;
    logic [7:0] sh = 8'h00;
    logic       addressed = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic [7:0] rd_reg = 8'h3C;
    logic       stretch_req = 1'b0;
    logic [8:0] obs_q[$];

    // Scoreboard
    logic [8:0] exp_frames[$];
    int         exp_nframes[$];
    logic [8:0] exp_rsp[$];
    logic [7:0] model_rsp_data = 8'h00;

    assign scl_i = scl_o & ~hold_low;
    assign sda_i = sda_o & slv_sda;

    i2c_single_reg_master #(.PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_o    (scl_o),
        .scl_t    (scl_t),
        .sda_o    (sda_o),
        .sda_t    (sda_t),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_read (cmd_read),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_nack (rsp_nack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rsp_valid) rsp_count <= rsp_count + 1;

    // Slave: START/STOP detect, shift on SCL rise, drive SDA after SCL fall.
    always @(posedge clk) begin
        prev_scl <= scl_i;
        prev_sda <= sda_i;
        if (hold_low && (scl_o || hold_cnt != 0)) begin
            if (hold_cnt == 39) hold_low <= 1'b0;
            hold_cnt <= hold_cnt + 1;
        end
        if (prev_scl && scl_i && prev_sda && !sda_i) begin
            fb <= 0;
            bi <= 0;
            slv_sda <= 1'b1;
        end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
            fb <= 0;
            bi <= 0;
            slv_sda <= 1'b1;
            addressed <= 1'b0;
        end else if (!prev_scl && scl_i) begin
            if (fb < 8) begin
                sh <= {sh[6:0], sda_i};
                fb <= fb + 1;
            end else begin
                obs_q.push_back({sh, sda_i});
                fb <= 0;
                bi <= bi + 1;
            end
        end else if (prev_scl && !scl_i) begin
            if (fb == 8 && bi == 0) begin
                if (sh[7:1] == SLAVE_ADDR) begin
                    slv_sda <= 1'b0;
                    addressed <= 1'b1;
                    rw <= sh[0];
                end else begin
                    slv_sda <= 1'b1;
                    addressed <= 1'b0;
                end
                if (stretch_req) begin
                    hold_low <= 1'b1;
                    hold_cnt <= 0;
                end
            end else if (fb == 8 && bi == 1 && addressed && !rw) begin
                slv_sda <= 1'b0;
                data_out <= sh;
            end else if (bi == 1 && fb < 8 && addressed && rw) begin
                slv_sda <= rd_reg[7-fb];
            end else begin
                slv_sda <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout/absent expected event", tag);
    endtask

    task automatic expect_txn(input logic rd, input logic [6:0] a, input logic [7:0] d);
        logic hit;
        hit = (a == SLAVE_ADDR);
        exp_frames.push_back({a, rd, !hit});
        if (hit) begin
            exp_frames.push_back(rd ? {rd_reg, 1'b1} : {d, 1'b0});
            exp_nframes.push_back(2);
            if (rd) model_rsp_data = rd_reg;
        end else begin
            exp_nframes.push_back(1);
        end
        exp_rsp.push_back({!hit, model_rsp_data});
    endtask

    task automatic check_rsp(input string tag);
        logic [8:0] e;
        logic [8:0] f;
        int n;
        if (exp_rsp.size() == 0) begin
            fail_now({tag, "_scoreboard_empty"});
            return;
        end
        e = exp_rsp.pop_front();
        chk({tag, "_rsp_nack"}, rsp_nack, e[8]);
        chk({tag, "_rsp_data"}, rsp_data, e[7:0]);
        n = exp_nframes.pop_front();
        for (int i = 0; i < n; i++) begin
            f = exp_frames.pop_front();
            if (obs_q.size() == 0) fail_now({tag, "_frame_missing"});
            else chk({tag, "_frame"}, obs_q.pop_front(), f);
        end
        chk({tag, "_extra_frames"}, obs_q.size(), 0);
    endtask

    task automatic issue(input logic rd, input logic [6:0] a, input logic [7:0] d,
                         output int t);
        @(negedge clk);
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4000 && !cmd_ready; i++) @(negedge clk);
        if (!cmd_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1 t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) fail_now("rsp_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, t3, rc;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_read = 1'b0;
        cmd_addr = 7'h00;
        cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_scl_o", scl_o, 1);
        chk("reset_sda_o", sda_o, 1);
        chk("reset_scl_t", scl_t, 1);
        chk("reset_sda_t", sda_t, 1);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 8'h00);
        chk("reset_rsp_nack", rsp_nack, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Write A5 to 0x70
        expect_txn(1'b0, 7'h70, 8'hA5);
        issue(1'b0, 7'h70, 8'hA5, t0);
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", cmd_ready, 0);
        wait_rsp(t1);
        chk("write_duration", t1 - t0, TXN);
        chk("write_rsp_ready", cmd_ready, 1);
        chk("write_rsp_busy", busy, 0);
        check_rsp("write");
        chk("write_slave_data", data_out, 8'hA5);
        @(negedge clk);
        chk("rsp_pulse_one_cycle", rsp_valid, 0);
        chk("idle_scl", scl_o, 1);
        chk("idle_sda", sda_o, 1);

        // Read 0x3C from 0x70
        rd_reg = 8'h3C;
        expect_txn(1'b1, 7'h70, 8'h00);
        issue(1'b1, 7'h70, 8'h00, t0);
        wait_rsp(t1);
        check_rsp("read");
        chk("read_slave_data_kept", data_out, 8'hA5);

        // Address NACK
        expect_txn(1'b0, 7'h71, 8'h55);
        issue(1'b0, 7'h71, 8'h55, t0);
        wait_rsp(t1);
        chk("nack_duration", t1 - t0, TXN - 9 * 4 * PRESCALE);
        check_rsp("addr_nack");
        chk("nack_slave_data_kept", data_out, 8'hA5);
        repeat (50) @(negedge clk);
        chk("rsp_nack_held", rsp_nack, 1);
        chk("rsp_data_held", rsp_data, 8'h3C);

        // Back-to-back: write 96 then read C3, second held valid throughout
        rd_reg = 8'hC3;
        expect_txn(1'b0, 7'h70, 8'h96);
        @(negedge clk);
        cmd_read = 1'b0;
        cmd_addr = 7'h70;
        cmd_wdata = 8'h96;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        cmd_read = 1'b1;
        expect_txn(1'b1, 7'h70, 8'h00);
        chk("b2b_ready_low_while_busy", cmd_ready, 0);
        wait_rsp(t1);
        chk("b2b_ready_on_rsp", cmd_ready, 1);
        chk("b2b_first_duration", t1 - t0, TXN);
        check_rsp("b2b_first");
        chk("b2b_slave_data", data_out, 8'h96);
        @(posedge clk);
        #1 t2 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_accept_gap", t2 - t0, TXN + 1);
        wait_rsp(t3);
        chk("b2b_second_duration", t3 - t2, TXN);
        check_rsp("b2b_second");

        // Reset during bit 3 of the data byte
        issue(1'b0, 7'h70, 8'h77, t0);
        while (cyc < t0 + 460) @(negedge clk);
        rc = rsp_count;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_scl_o", scl_o, 1);
        chk("abort_sda_o", sda_o, 1);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_rsp_data", rsp_data, 8'h00);
        rst = 1'b1;
        model_rsp_data = 8'h00;
        chk("abort_frames", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("abort_addr_frame", obs_q.pop_front(), 9'h1C0);
        obs_q.delete();
        repeat (700) @(negedge clk);
        chk("abort_no_rsp", rsp_count, rc);
        chk("abort_slave_data_kept", data_out, 8'h96);
        expect_txn(1'b0, 7'h70, 8'h0F);
        issue(1'b0, 7'h70, 8'h0F, t0);
        wait_rsp(t1);
        check_rsp("post_abort_write");
        chk("post_abort_slave_data", data_out, 8'h0F);

        // Clock stretch in the address ACK slot
        stretch_req = 1'b1;
`ifdef I2C_MASTER_CLK_STRETCH_EN
        expect_txn(1'b0, 7'h70, 8'h5A);
`endif
        issue(1'b0, 7'h70, 8'h5A, t0);
        stretch_req = 1'b0;
        wait_rsp(t1);
        chk("stretch_duration", t1 - t0, TXN + STRETCH_EXTRA);
`ifdef I2C_MASTER_CLK_STRETCH_EN
        check_rsp("stretch");
        chk("stretch_slave_data", data_out, 8'h5A);
`else
        obs_q.delete();
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
